// File: rtl/thruster_pkg.sv
// Shared types and defaults for the attitude controller slice.
// Holds the FSM state encoding and default sizing constants.
package thruster_pkg;

  localparam int N_DEF       = 4;
  localparam int VMAX_DEF    = 2;
  localparam int TMAX_DEF    = 3;
  localparam int TIMEOUT_DEF = 63;

  typedef enum logic [1:0] {
    IDLE,
    SEEK,
    HOLD
  } state_t;

endpackage

// File: rtl/attitude_controller_if.sv
// Command handshake between a move requester and the controller.
// The requester drives valid/target; the controller answers ready.
interface attitude_controller_if #(
  parameter int N = 4
) ();

  logic         cmd_valid;
  logic [N-1:0] cmd_target;
  logic         cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_target,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_target,
    output cmd_ready
  );

endinterface

// File: rtl/attitude_controller_angle_error.sv
// Shortest-path angle error on an N-bit circle.
// A half-turn wraps to the most negative value.
module angle_error #(
  parameter int N = 4
) (
  input  logic [N-1:0]        target,
  input  logic [N-1:0]        angle,
  output logic signed [N-1:0] err
);

  logic [N-1:0] diff;

  assign diff = target - angle;
  assign err  = $signed(diff);

endmodule

// File: rtl/attitude_controller.sv
// Angle-seeking thruster controller: IDLE/SEEK/HOLD FSM with a
// clamped velocity profile and a per-move timeout.
module attitude_controller
  import thruster_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int VMAX    = VMAX_DEF,
  parameter int TMAX    = TMAX_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  attitude_controller_if.slave cmd,
  input  logic                abort,
  input  logic [N-1:0]        angle,
  input  logic signed [N-1:0] velocity,
  output logic                up,
  output logic                down,
  output logic [N-1:0]        thrust,
  output logic                busy,
  output logic                done,
  output logic                fault
);

  localparam logic signed [N-1:0] VP = VMAX[N-1:0];
  localparam logic signed [N-1:0] VN = -VP;
  localparam logic [N:0]          TM = TMAX[N:0];
  localparam logic [7:0]          TO = TIMEOUT[7:0];

  state_t state, state_n;

  logic [N-1:0] target_q, target_n;
  logic [7:0]   cnt_q, cnt_n, cnt_inc;
  logic         ready_q, ready_n;
  logic         up_n, down_n;
  logic [N-1:0] thrust_n, thrust_c;
  logic         done_n, fault_n;

  logic signed [N-1:0] err, sh, vd;
  logic signed [N:0]   delta;
  logic [N:0]          mag;

  angle_error #(.N(N)) u_err (
    .target (target_q),
    .angle  (angle),
    .err    (err)
  );

  // Small errors still creep toward the target at unit speed.
  always_comb begin
    sh = err >>> 1;
    vd = sh;
    if (err != '0 && sh == '0)
      vd = err[N-1] ? {N{1'b1}} : {{(N-1){1'b0}}, 1'b1};
    else if (sh > VP)
      vd = VP;
    else if (sh < VN)
      vd = VN;
  end

  assign delta    = {vd[N-1], vd} - {velocity[N-1], velocity};
  assign mag      = delta[N] ? (~delta + 1'b1) : delta;
  assign thrust_c = (mag > TM) ? TM[N-1:0] : mag[N-1:0];
  assign cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_n  = state;
    target_n = target_q;
    cnt_n    = cnt_q;
    up_n     = 1'b0;
    down_n   = 1'b0;
    thrust_n = '0;
    done_n   = 1'b0;
    fault_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd.cmd_valid && ready_q) begin
          target_n = cmd.cmd_target;
          cnt_n    = '0;
          state_n  = SEEK;
        end
      end
      SEEK: begin
        cnt_n = cnt_inc;
        if (abort) begin
          state_n = IDLE;
        end else if (err == '0 && velocity == '0) begin
          done_n  = 1'b1;
          state_n = HOLD;
        end else if (cnt_inc >= TO) begin
          fault_n = 1'b1;
          state_n = HOLD;
        end else begin
          thrust_n = thrust_c;
          unique case (1'b1)
            delta[N]:                      down_n = 1'b1;
            (!delta[N] && delta != '0):    up_n   = 1'b1;
            default: ;
          endcase
        end
      end
      HOLD:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    ready_n = (state_n == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      target_q <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      up       <= 1'b0;
      down     <= 1'b0;
      thrust   <= '0;
      done     <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state    <= state_n;
      target_q <= target_n;
      cnt_q    <= cnt_n;
      ready_q  <= ready_n;
      up       <= up_n;
      down     <= down_n;
      thrust   <= thrust_n;
      done     <= done_n;
      fault    <= fault_n;
    end
  end

  assign busy          = (state == SEEK);
  assign cmd.cmd_ready = ready_q;

endmodule

// File: tb/tb_attitude_controller.sv
// Self-checking bench for attitude_controller: vector table, corner
// sequences, closed thruster loop and randomized model comparison.
module tb_attitude_controller;

  localparam int N       = 4;
  localparam int VMAX    = 2;
  localparam int TMAX    = 3;
  localparam int TIMEOUT = 63;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       abort    = 1'b0;
  logic [3:0] angle    = 4'd0;
  logic [3:0] velocity = 4'd0;
  logic       up, down, busy, done, fault;
  logic [3:0] thrust;

  attitude_controller_if #(.N(N)) cmd_if ();

  attitude_controller #(
    .N(N), .VMAX(VMAX), .TMAX(TMAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd      (cmd_if),
    .abort    (abort),
    .angle    (angle),
    .velocity (velocity),
    .up       (up),
    .down     (down),
    .thrust   (thrust),
    .busy     (busy),
    .done     (done),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int s4(input logic [3:0] v);
    return (v >= 4'd8) ? int'(v) - 16 : int'(v);
  endfunction

  function automatic int werr(input int tgt, input int a);
    int e;
    e = (((tgt - a) % 16) + 16) % 16;
    if (e >= 8) e -= 16;
    return e;
  endfunction

  // Signed thrust request: positive means up.
  function automatic int law(input int tgt, input int a, input int v);
    int e, vd, u;
    e  = werr(tgt, a);
    vd = (e >= 0) ? e / 2 : -((1 - e) / 2);
    if (e != 0 && vd == 0) vd = (e > 0) ? 1 : -1;
    if (vd > VMAX) vd = VMAX;
    if (vd < -VMAX) vd = -VMAX;
    u = vd - v;
    if (u > TMAX) u = TMAX;
    if (u < -TMAX) u = -TMAX;
    return u;
  endfunction

  function automatic logic [9:0] pack(input bit u, input bit d,
                                      input int t, input bit b,
                                      input bit dn, input bit f,
                                      input bit r);
    logic [3:0] t4;
    t4 = t[3:0];
    return {u, d, t4, b, dn, f, r};
  endfunction

  function automatic logic [9:0] dut_out();
    return {up, down, thrust, busy, done, fault, cmd_if.cmd_ready};
  endfunction

  int         m_ph  = 0;
  int         m_tgt = 0;
  int         m_cnt = 0;
  bit         m_rdy = 1'b0;
  logic [9:0] m_out = '0;

  task automatic model_reset();
    m_ph  = 0;
    m_tgt = 0;
    m_cnt = 0;
    m_rdy = 1'b0;
    m_out = '0;
  endtask

  // Phase 0 waits for a command, 1 is moving, 2 is the settle beat.
  task automatic model_step();
    int u;
    bit dn, f;
    u  = 0;
    dn = 1'b0;
    f  = 1'b0;
    if (m_ph == 1) begin
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      if (abort) m_ph = 0;
      else if (werr(m_tgt, int'(angle)) == 0 && s4(velocity) == 0) begin
        dn   = 1'b1;
        m_ph = 2;
      end else if (m_cnt >= TIMEOUT) begin
        f    = 1'b1;
        m_ph = 2;
      end else u = law(m_tgt, int'(angle), s4(velocity));
    end else if (m_ph == 2) begin
      m_ph = 0;
    end else if (m_rdy && cmd_if.cmd_valid) begin
      m_tgt = int'(cmd_if.cmd_target);
      m_cnt = 0;
      m_ph  = 1;
    end
    m_rdy = (m_ph == 0);
    m_out = pack(u > 0, u < 0, (u < 0) ? -u : u, m_ph == 1, dn, f, m_rdy);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model", {22'd0, dut_out()}, {22'd0, m_out});
  endtask

  task automatic issue(input logic [3:0] tgt);
    @(negedge clk);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_target = tgt;
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  typedef struct {
    logic [3:0] tgt;
    logic [3:0] ang;
    logic [3:0] vel;
    logic       up;
    logic       dn;
    logic [3:0] th;
  } vec_t;

  vec_t vt[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k_at, steps, vi;
    bit got, first;

    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_target = 4'd0;

    vt[0] = '{4'd3,  4'd0, 4'd0,  1'b1, 1'b0, 4'd1};
    vt[1] = '{4'd10, 4'd0, 4'd0,  1'b0, 1'b1, 4'd2};
    vt[2] = '{4'd8,  4'd0, 4'd0,  1'b0, 1'b1, 4'd2};
    vt[3] = '{4'd1,  4'd0, 4'd0,  1'b1, 1'b0, 4'd1};
    vt[4] = '{4'd15, 4'd0, 4'd0,  1'b0, 1'b1, 4'd1};
    vt[5] = '{4'd0,  4'd0, 4'd5,  1'b0, 1'b1, 4'd3};
    vt[6] = '{4'd4,  4'd0, 4'd8,  1'b1, 1'b0, 4'd3};
    vt[7] = '{4'd2,  4'd0, 4'd1,  1'b0, 1'b0, 4'd0};
    vt[8] = '{4'd7,  4'd0, 4'd7,  1'b0, 1'b1, 4'd3};
    vt[9] = '{4'd5,  4'd3, 4'd15, 1'b1, 1'b0, 4'd2};

    model_reset();
    #2;
    check("reset_outs", {22'd0, dut_out()}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("ready_after_reset", cmd_if.cmd_ready, 1);

    angle    = 4'd0;
    velocity = 4'd0;
    issue(4'd0);
    check("zero_busy", busy, 1);
    check("zero_ready_low", cmd_if.cmd_ready, 0);
    tick();
    check("zero_done", done, 1);
    check("zero_no_thrust", {up, down}, 0);
    tick();
    check("zero_done_clear", done, 0);
    check("zero_ready_back", cmd_if.cmd_ready, 1);

    for (int i = 0; i < 10; i++) begin
      angle    = vt[i].ang;
      velocity = vt[i].vel;
      issue(vt[i].tgt);
      tick();
      check($sformatf("vec%0d_up", i), up, vt[i].up);
      check($sformatf("vec%0d_down", i), down, vt[i].dn);
      check($sformatf("vec%0d_thrust", i), thrust, vt[i].th);
      @(negedge clk);
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end

    angle    = 4'd0;
    velocity = 4'd0;
    issue(4'd3);
    tick();
    check("abort_pre_up", up, 1);
    @(negedge clk);
    abort = 1'b1;
    tick();
    check("abort_outs", {up, down, thrust, done, fault}, 0);
    check("abort_ready", cmd_if.cmd_ready, 1);
    @(negedge clk);
    abort = 1'b0;
    tick();
    check("abort_no_pulse", {done, fault}, 0);

    issue(4'd3);
    tick();
    check("rst_pre_up", up, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {22'd0, dut_out()}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    issue(4'd5);
    k_at = 0;
    for (int k = 1; k <= 300 && k_at == 0; k++) begin
      tick();
      if (fault) k_at = k;
    end
    check("timeout_cycles", k_at, TIMEOUT);
    check("timeout_outs", {up, down, thrust, done}, 0);
    tick();
    check("timeout_fault_clear", fault, 0);
    check("timeout_ready", cmd_if.cmd_ready, 1);

    angle    = 4'd0;
    velocity = 4'd0;
    issue(4'd8);
    got   = 1'b0;
    first = 1'b1;
    steps = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      tick();
      if (first) begin
        check("loop_first_down", down, 1);
        first = 1'b0;
      end
      if (done) begin
        got   = 1'b1;
        steps = k + 1;
      end
      vi = s4(velocity) + (up ? int'(thrust) : 0) - (down ? int'(thrust) : 0);
      velocity = vi[3:0];
      angle    = angle + velocity;
    end
    check("loop_done", got, 1);
    check("loop_in_time", steps < TIMEOUT, 1);
    check("loop_angle", angle, 8);
    check("loop_velocity", velocity, 0);
    tick();

    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      cmd_if.cmd_valid  = ($urandom_range(0, 3) == 0);
      cmd_if.cmd_target = 4'($urandom_range(0, 15));
      abort             = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 3) == 0) begin
        angle    = m_tgt[3:0];
        velocity = 4'd0;
      end else begin
        angle    = 4'($urandom_range(0, 15));
        velocity = 4'($urandom_range(0, 15));
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
